// File: rtl/t_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : t_flipflop
// Description : Bank of WIDTH independent T flip-flops with clock enable,
//               synchronous parallel load, complementary output and a
//               per-bit toggle-event flag.
// Revision    : 1.0 - initial release
// ============================================================================
module t_flipflop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] toggled
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_toggled;

    // Load outranks enable, so a load always clears the toggle flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= RESET_VALUE;
            r_toggled <= '0;
        end else if (load) begin
            r_q       <= load_val;
            r_toggled <= '0;
        end else if (en) begin
            r_q       <= r_q ^ d;
            r_toggled <= d;
        end else begin
            r_toggled <= '0;
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign toggled = r_toggled;

endmodule
`default_nettype wire

// File: tb/tb_t_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_flipflop
// Description : Self-checking bench for t_flipflop (zero and non-zero reset
//               value builds, plus a 1-bit build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_flipflop;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic       en;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] q0, qn0, tg0;
    logic [3:0] q1, qn1, tg1;
    logic       qw, qnw, tgw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       load;
        logic       en;
        logic [3:0] d;
        logic [3:0] lv;
        logic [3:0] eq;
        logic [3:0] et;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic [3:0] tog;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    t_flipflop #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut0 (
        .clk(clk), .rst(rst), .d(d), .en(en), .load(load), .load_val(load_val),
        .q(q0), .qn(qn0), .toggled(tg0)
    );

    t_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1001)) dut1 (
        .clk(clk), .rst(rst), .d(d), .en(en), .load(load), .load_val(load_val),
        .q(q1), .qn(qn1), .toggled(tg1)
    );

    t_flipflop #(.WIDTH(1)) dutw (
        .clk(clk), .rst(rst), .d(d[0]), .en(en), .load(load), .load_val(load_val[0]),
        .q(qw), .qn(qnw), .toggled(tgw)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ld, input logic e, input logic [3:0] dv,
                       input logic [3:0] lv, input logic [3:0] eq, input logic [3:0] et);
        vec_t v;
        v.load = ld; v.en = e; v.d = dv; v.lv = lv; v.eq = eq; v.et = et;
        vecs.push_back(v);
    endtask

    // Drive one vector at the falling edge, compare just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        load = v.load; en = v.en; d = v.d; load_val = v.lv;
        e.q = v.eq; e.tog = v.et; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d q0", e.idx), q0, e.q);
        chk($sformatf("vec%0d qn0", e.idx), qn0, ~e.q);
        chk($sformatf("vec%0d tog0", e.idx), tg0, e.tog);
        chk($sformatf("vec%0d q1", e.idx), q1, e.q);
        chk($sformatf("vec%0d qw", e.idx), {3'b0, qw}, {3'b0, e.q[0]});
        chk($sformatf("vec%0d qnw", e.idx), {3'b0, qnw}, {3'b0, ~e.q[0]});
        chk($sformatf("vec%0d togw", e.idx), {3'b0, tgw}, {3'b0, e.tog[0]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Loads align both 4-bit builds; afterwards their q must match.
        add(1, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'hF, 4'hA, 4'hA, 4'h0);
        add(0, 1, 4'hF, 4'h0, 4'h5, 4'hF);
        add(0, 1, 4'h0, 4'h0, 4'h5, 4'h0);
        add(0, 1, 4'h1, 4'h0, 4'h4, 4'h1);
        add(0, 0, 4'hF, 4'h0, 4'h4, 4'h0);
        add(0, 0, 4'hF, 4'h0, 4'h4, 4'h0);
        add(0, 0, 4'hF, 4'h0, 4'h4, 4'h0);
        add(0, 1, 4'hF, 4'h0, 4'hB, 4'hF);
        add(1, 0, 4'hF, 4'h6, 4'h6, 4'h0);
        add(0, 1, 4'h8, 4'h0, 4'hE, 4'h8);
        add(0, 1, 4'h6, 4'h0, 4'h8, 4'h6);
        // Divide-by-2 from zero
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 4'hF, 4'h0, (i % 2 == 0) ? 4'hF : 4'h0, 4'hF);
        // Basic T sequence on bit 0: d = 0,1,0,1,1,1
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h1, 4'h0, 4'h1, 4'h1);
        add(0, 1, 4'h0, 4'h0, 4'h1, 4'h0);
        add(0, 1, 4'h1, 4'h0, 4'h0, 4'h1);
        add(0, 1, 4'h1, 4'h0, 4'h1, 4'h1);
        add(0, 1, 4'h1, 4'h0, 4'h0, 4'h1);
        // Bits independent; leaves q = 0110 for the mid-run reset
        add(1, 1, 4'h0, 4'h6, 4'h6, 4'h0);

        // Reset held with d=1 and clock running
        rst = 1'b1; d = 4'hF; en = 1'b1; load = 1'b0; load_val = 4'h0;
        #1;
        chk("rst_async q0", q0, 4'h0);
        chk("rst_async q1", q1, 4'h9);
        chk("rst_async qn1", qn1, 4'h6);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            load = (c == 1); load_val = 4'hA;
            chk("rst_hold q0", q0, 4'h0);
            chk("rst_hold qn0", qn0, 4'hF);
            chk("rst_hold tog0", tg0, 4'h0);
            chk("rst_hold q1", q1, 4'h9);
            chk("rst_hold tog1", tg1, 4'h0);
            chk("rst_hold qw", {3'b0, qw}, 4'h0);
        end
        @(negedge clk);
        chk("rst_vs_load q0", q0, 4'h0);
        chk("rst_vs_load q1", q1, 4'h9);
        rst = 1'b0; load = 1'b0;
        @(posedge clk);
        #1;
        chk("release q0", q0, 4'hF);
        chk("release tog0", tg0, 4'hF);
        chk("release q1", q1, 4'h6);
        chk("release qw", {3'b0, qw}, 4'h1);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Asynchronous reset pulse between edges
        @(negedge clk);
        load = 1'b0; en = 1'b1; d = 4'h1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst q0", q0, 4'h0);
        chk("midrst qn0", qn0, 4'hF);
        chk("midrst tog0", tg0, 4'h0);
        chk("midrst q1", q1, 4'h9);
        chk("midrst qn1", qn1, 4'h6);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_midrst q0", q0, 4'h1);
        chk("post_midrst q1", q1, 4'h8);
        chk("post_midrst tog1", tg1, 4'h1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t_flipflop.md
Name: t_flipflop

Overview:
- Parameterised T (toggle) flip-flop bank. Each bit of `q` inverts on a rising clock edge when its toggle input `d` is 1, and holds when it is 0.
- Used as a generic toggle/divide-by-2 primitive and as a per-bit toggle register in control logic.
- Adds a clock enable, a synchronous parallel load, a complementary output and a per-bit toggle-event flag around the basic T function.

Parameters:
- WIDTH, 1, number of independent T flip-flops (≥1).
- RESET_VALUE, {WIDTH{1'b0}}, value of `q` on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- d  input  WIDTH  per-bit toggle request (T input).
- en  input  1  clock enable; tie to 1 for plain T-FF behaviour.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when `load`=1.
- q  output  WIDTH  registered state.
- qn  output  WIDTH  bitwise complement of `q` (combinational from `q`).
- toggled  output  WIDTH  registered flag: bit i = 1 for the cycle after bit i of `q` toggled.

Behaviour:
- Reset (asynchronous, active-high):
  - While `rst`=1, `q`=RESET_VALUE, `qn`=~RESET_VALUE and `toggled`=0, independent of `clk`.
  - Deassertion takes effect at the next rising edge; there is no extra latency.
- Priority at each rising `clk` edge with `rst`=0:
  1. `load`=1: `q` <= `load_val`; `toggled` <= 0. `load` works regardless of `en`.
  2. `en`=0: `q` holds; `toggled` <= 0.
  3. `en`=1: `q` <= `q` ^ `d`; `toggled` <= `d`.
- Latency: one clock. `q` updates only at the rising edge. Changes on `d` between edges have no effect.
- `d` is sampled at the rising edge. `d` held at 1 makes `q` oscillate at clk/2 (divide-by-2).
- `d` = 0 holds `q` indefinitely.
- Bits are fully independent. No carry or interaction between bits.
- Reset asserted mid-stream: `q` snaps immediately to RESET_VALUE and the toggle history is lost. The first edge after release toggles from RESET_VALUE.
- Simultaneous `load` and `d`=1: the load wins and no toggle occurs.
- Simultaneous `rst` and `load`: reset wins.
- `qn` is always exactly ~`q`, including during reset.
- No X propagation from an undriven `en`/`load`. The integrating design must tie unused controls (`en`=1, `load`=0).

Test Plan:
- Reset: assert `rst`=1 for 2 cycles with `d`=1 and `clk` running -> `q`=0, `qn`=1 and `toggled`=0 throughout. Release -> first rising edge gives `q`=1.
- Basic T sequence: WIDTH=1, `en`=1, `clk` period 10 with rising edges at 5, 15, 25…, `d` changes at 10/20/30/40 to 0, 1, 0, 1 -> `q` stays 0 at edge 15, becomes 1 at 25, holds 1 at 35, becomes 0 at 45, then alternates 1/0 every edge while `d`=1.
- Divide-by-2: `d`=1 held for 8 edges from `q`=0 -> `q` = 1, 0, 1, 0, 1, 0, 1, 0 and `toggled`=1 every cycle.
- Enable gating: `d`=1, `en`=0 for 3 edges -> `q` unchanged and `toggled`=0. Re-enable -> toggles on the next edge.
- Load priority: WIDTH=4, `q`=4'b0000, `d`=4'b1111, `load`=1, `load_val`=4'b1010 -> `q`=4'b1010 and `toggled`=0. The next edge with `load`=0 gives `q`=4'b0101.
- Async reset mid-operation: WIDTH=4, `q`=4'b0110, pulse `rst` between edges -> `q`=RESET_VALUE (0) immediately without a clock edge. Check non-zero RESET_VALUE=4'b1001 in a second build -> `q`=4'b1001 and `qn`=4'b0110.
